// File: rtl/traffic_cmd_deframer.sv
// traffic_cmd_deframer: checks framed host command bytes and issues single-cycle cmd strobes.
// Define TRAFFIC_CMD_CHECKSUM_EN to require a 4th XOR checksum byte per frame.
module traffic_cmd_deframer #(
    parameter int TIMEOUT_TICKS = 2000,
    parameter int INTER_CMD_GAP = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk_0m002,
    input  logic                 arst_n_i,
    input  logic [7:0]           byte_data_i,
    input  logic                 byte_val_i,
    output logic                 byte_rdy_o,
    output logic [2:0]           cmd_type_o,
    output logic [15:0]          cmd_data_o,
    output logic                 cmd_val_o,
    output logic                 frame_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 busy_o
);
    localparam logic [4:0] SYNC = 5'b10100;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS);
    localparam int GAP_W = INTER_CMD_GAP > 1 ? $clog2(INTER_CMD_GAP) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(INTER_CMD_GAP > 0 ? INTER_CMD_GAP - 1 : 0);

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, GOT_TYPE, GOT_HI, CHK, EMIT, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, GOT_TYPE, GOT_HI, EMIT, GAP} state_t;
`endif

    state_t             state_q, state_d;
    logic               rdy_en_q;
    logic               accept, in_frame, timeout, type_ok, err_d, emit_d;
    logic [2:0]         type_q;
    logic [7:0]         hi_q;
    logic [15:0]        emit_data;
    logic [TO_W-1:0]    to_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    logic [7:0]         lo_q;
    assign emit_data = {hi_q, lo_q};
`else
    assign emit_data = {hi_q, byte_data_i};
`endif

    // rdy_en_q keeps byte_rdy_o low until the first edge after reset release
    assign byte_rdy_o = rdy_en_q && state_q != EMIT && state_q != GAP;
    assign in_frame   = state_q != IDLE && state_q != EMIT && state_q != GAP;
    assign accept     = byte_val_i && byte_rdy_o;
    assign timeout    = in_frame && !accept && to_cnt_q == TO_LAST;
    assign type_ok    = type_q <= 3'd5;
    assign cmd_val_o  = state_q == EMIT;
    assign busy_o     = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        emit_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (byte_data_i[7:3] == SYNC) state_d = GOT_TYPE;
                else err_d = 1'b1;
            end
            GOT_TYPE: if (accept) state_d = GOT_HI;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            GOT_HI: if (accept) state_d = CHK;
            CHK: if (accept) begin
                emit_d  = type_ok && byte_data_i == ({SYNC, type_q} ^ hi_q ^ lo_q);
                err_d   = !emit_d;
                state_d = emit_d ? EMIT : IDLE;
            end
`else
            GOT_HI: if (accept) begin
                emit_d  = type_ok;
                err_d   = !type_ok;
                state_d = type_ok ? EMIT : IDLE;
            end
`endif
            EMIT: state_d = INTER_CMD_GAP > 0 ? GAP : IDLE;
            GAP: if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            rdy_en_q    <= 1'b0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            type_q      <= '0;
            hi_q        <= '0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            lo_q        <= '0;
`endif
            cmd_type_o  <= '0;
            cmd_data_o  <= '0;
            frame_err_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            to_cnt_q    <= (in_frame && !accept && state_d != IDLE) ? to_cnt_q + 1'b1 : '0;
            gap_cnt_q   <= state_q == GAP ? gap_cnt_q + 1'b1 : '0;
            frame_err_o <= err_d;
            if (err_d && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + 1'b1;
            if (state_q == IDLE && accept) type_q <= byte_data_i[2:0];
            if (state_q == GOT_TYPE && accept) hi_q <= byte_data_i;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            if (state_q == GOT_HI && accept) lo_q <= byte_data_i;
`endif
            if (emit_d) begin
                cmd_type_o <= type_q;
                cmd_data_o <= emit_data;
            end
        end
    end
endmodule

// File: tb/tb_traffic_cmd_deframer.sv
// tb_traffic_cmd_deframer: directed and random byte streams against a frame-level reference model.
module tb_traffic_cmd_deframer;
    localparam int TO  = 2000;
    localparam int GAP = 2;
    localparam int EW  = 8;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic          clk_0m002 = 1'b0;
    logic          arst_n_i = 1'b1;
    logic [7:0]    byte_data_i = '0;
    logic          byte_val_i = 1'b0;
    logic          byte_rdy_o;
    logic [2:0]    cmd_type_o;
    logic [15:0]   cmd_data_o;
    logic          cmd_val_o;
    logic          frame_err_o;
    logic [EW-1:0] err_cnt_o;
    logic          busy_o;

    traffic_cmd_deframer #(.TIMEOUT_TICKS(TO), .INTER_CMD_GAP(GAP), .ERR_CNT_W(EW)) dut (
        .clk_0m002(clk_0m002), .arst_n_i(arst_n_i), .byte_data_i(byte_data_i),
        .byte_val_i(byte_val_i), .byte_rdy_o(byte_rdy_o), .cmd_type_o(cmd_type_o),
        .cmd_data_o(cmd_data_o), .cmd_val_o(cmd_val_o), .frame_err_o(frame_err_o),
        .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_0m002 = ~clk_0m002;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] d;
        logic [31:0] at;
    } cmd_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    cmd_t exp_q[$];
    int rd = 0;
    int pulses = 0;
    int run = 0;
    logic [2:0] last_t = '0;
    logic [15:0] last_d = '0;
    logic [7:0] fbuf [4];
    int pos = 0;
    int m_err = 0;
    int last_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_0m002) cyc <= cyc + 1;

    always @(negedge clk_0m002) begin
        if (!arst_n_i) begin
            rd     <= exp_q.size();
            pulses <= 0;
            run    <= 0;
            last_t <= '0;
            last_d <= '0;
        end else begin
            if (frame_err_o) pulses <= pulses + 1;
            if (cmd_val_o) begin
                if (rd < exp_q.size()) begin
                    check("cmd_type", 32'(cmd_type_o), 32'(exp_q[rd].t));
                    check("cmd_data", 32'(cmd_data_o), 32'(exp_q[rd].d));
                    check("cmd_cycle", 32'(cyc), exp_q[rd].at);
                    rd <= rd + 1;
                end else check("cmd_unexpected", 32'(cmd_val_o), 32'd0);
                last_t <= cmd_type_o;
                last_d <= cmd_data_o;
            end else begin
                check("hold_type", 32'(cmd_type_o), 32'(last_t));
                check("hold_data", 32'(cmd_data_o), 32'(last_d));
            end
            if (busy_o && !byte_rdy_o) run <= run + 1;
            else if (run != 0) begin
                check("stall_len", 32'(run), 32'(1 + GAP));
                run <= 0;
            end
        end
    end

    // Frame-level model: a mid-frame gap longer than TO accept edges means a timeout occurred
    task automatic model_byte(input logic [7:0] b, input int acc);
        logic ok;
        if (pos > 0 && acc - last_acc > TO) begin
            m_err++;
            pos = 0;
        end
        last_acc = acc;
        if (pos == 0) begin
            if (b[7:3] == 5'b10100) begin
                fbuf[0] = b;
                pos = 1;
            end else m_err++;
        end else begin
            fbuf[pos] = b;
            pos++;
            if (pos == FLEN) begin
                pos = 0;
                ok = fbuf[0][2:0] <= 3'd5;
                if (FLEN == 4 && fbuf[3] != (fbuf[0] ^ fbuf[1] ^ fbuf[2])) ok = 1'b0;
                if (ok) exp_q.push_back('{t: fbuf[0][2:0], d: {fbuf[1], fbuf[2]}, at: 32'(acc)});
                else m_err++;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        int n = 0;
        int acc;
        if (idle > 0) begin
            byte_val_i = 1'b0;
            repeat (idle) @(negedge clk_0m002);
        end
        byte_val_i  = 1'b1;
        byte_data_i = b;
        while (!byte_rdy_o && n < 64) begin
            @(negedge clk_0m002);
            n++;
        end
        check("rdy_wait", 32'(byte_rdy_o), 32'd1);
        if (!byte_rdy_o) begin
            byte_val_i = 1'b0;
            return;
        end
        acc = cyc + 1;
        model_byte(b, acc);
        @(negedge clk_0m002);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int i0, input int i2);
        send(b0, i0);
        send(b1, 0);
        send(b2, i2);
        if (FLEN == 4) send(b0 ^ b1 ^ b2, 0);
    endtask

    task automatic checkpoint();
        byte_val_i = 1'b0;
        if (pos > 0) begin
            repeat (TO + 5) @(negedge clk_0m002);
            m_err++;
            pos = 0;
        end else repeat (8) @(negedge clk_0m002);
        check("err_cnt", 32'(err_cnt_o), 32'(m_err > 255 ? 255 : m_err));
        check("err_pulses", 32'(pulses), 32'(m_err));
        check("cmd_pending", 32'(exp_q.size() - rd), 32'd0);
    endtask

    task automatic do_reset();
        byte_val_i = 1'b0;
        arst_n_i   = 1'b0;
        pos        = 0;
        m_err      = 0;
        repeat (2) @(negedge clk_0m002);
        arst_n_i = 1'b1;
    endtask

    function automatic int pick_idle();
        int r = $urandom_range(0, 99);
        if (r == 0) return TO - 2 + $urandom_range(0, 2);
        return r < 70 ? 0 : $urandom_range(1, 3);
    endfunction

    initial begin
        logic [7:0] b0, b1, b2, cs;
        #1 arst_n_i = 1'b0;
        repeat (2) @(negedge clk_0m002);
        check("rst_rdy", 32'(byte_rdy_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_val", 32'(cmd_val_o), 0);
        check("rst_err", 32'(frame_err_o), 0);
        check("rst_cnt", 32'(err_cnt_o), 0);
        check("rst_cmd", 32'({cmd_type_o, cmd_data_o}), 0);
        arst_n_i = 1'b1;
        #1 check("rdy_before_edge", 32'(byte_rdy_o), 0);
        @(negedge clk_0m002);
        check("rdy_after_edge", 32'(byte_rdy_o), 1);

        send_frame(8'hA3, 8'h00, 8'h0A, 0, 0);
        checkpoint();
        send_frame(8'hA2, 8'h00, 8'h00, 0, 0);
        send_frame(8'hA3, 8'h00, 8'h0A, 0, 0);
        send_frame(8'hA4, 8'h00, 8'h0A, 0, 0);
        send_frame(8'hA5, 8'h00, 8'h0A, 0, 0);
        send_frame(8'hA0, 8'h00, 8'h00, 0, 0);
        checkpoint();
        send(8'h55, 0);
        send_frame(8'hA4, 8'h00, 8'h0F, 0, 0);
        checkpoint();
        send_frame(8'hA6, 8'h12, 8'h34, 0, 0);
        checkpoint();

        send(8'hA3, 0);
        send(8'h00, 0);
        check("busy_mid", 32'(busy_o), 1);
        send_frame(8'hA5, 8'h00, 8'h0A, TO, 0);
        checkpoint();
        send(8'hA3, 0);
        send(8'h00, 0);
        send(8'hA5, TO - 1);
        if (FLEN == 4) send(8'hA3 ^ 8'h00 ^ 8'hA5, 0);
        checkpoint();

`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send(8'hA3, 0); send(8'h00, 0); send(8'h0A, 0); send(8'hA9, 0);
        send(8'hA3, 0); send(8'h00, 0); send(8'h0A, 0); send(8'h00, 0);
        checkpoint();
`endif

        for (int i = 0; i < 260; i++) send(8'h00, 0);
        checkpoint();
        send_frame(8'hA1, 8'hBE, 8'hEF, 0, 0);
        checkpoint();

        send(8'hA3, 0);
        send(8'h00, 0);
        byte_val_i = 1'b0;
        arst_n_i = 1'b0;
        #1 check("midrst_cnt", 32'(err_cnt_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        do_reset();
        checkpoint();

        for (int f = 0; f < 250; f++) begin
            b0 = ($urandom_range(0, 11) == 0) ? 8'($urandom) : {5'b10100, 3'($urandom)};
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            cs = b0 ^ b1 ^ b2;
            if ($urandom_range(0, 7) == 0) cs ^= 8'($urandom_range(1, 255));
            send(b0, pick_idle());
            send(b1, pick_idle());
            send(b2, pick_idle());
            if (FLEN == 4) send(cs, pick_idle());
            if (f % 50 == 49) checkpoint();
        end
        checkpoint();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/traffic_cmd_deframer.md
Name: traffic_cmd_deframer

Overview:
- Upstream command source for traffic_lights.
- Receives a byte stream (valid/ready) of framed commands, checks framing, type and timeout, then issues single-cycle cmd_val pulses with cmd_type/cmd_data.
- Sits between the host byte link and the traffic_lights cmd_* inputs, in the same 2 kHz clk_0m002 domain.

Parameters:
- TIMEOUT_TICKS, 2000: max clk cycles allowed between bytes of one frame (1 s at 2 kHz); range 2..65535.
- INTER_CMD_GAP, 2: idle cycles after each cmd_val pulse before the next byte is accepted; 0 allowed.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk_0m002  in  1  system clock, 2 kHz.
- arst_n_i  in  1  asynchronous active-low reset.
- byte_data_i  in  8  incoming byte.
- byte_val_i  in  1  byte_data_i valid.
- byte_rdy_o  out  1  deframer can accept a byte; transfer occurs when byte_val_i && byte_rdy_o.
- cmd_type_o  out  3  command type to traffic_lights.
- cmd_data_o  out  16  command data to traffic_lights.
- cmd_val_o  out  1  one-cycle command strobe.
- frame_err_o  out  1  one-cycle pulse per rejected frame or byte.
- err_cnt_o  out  ERR_CNT_W  saturating count of frame_err_o pulses.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock (clk_0m002); reset is asynchronous, active-low (arst_n_i).
- Reset values: all outputs 0, state IDLE, timeout counter 0, err_cnt_o 0. byte_rdy_o goes to 1 on the first clock edge after reset release.
- Frame format: byte0 = {5'b10100, type[2:0]}, byte1 = data[15:8], byte2 = data[7:0].
- States: IDLE, GOT_TYPE, GOT_HI, (CHK), EMIT, GAP.
- byte_rdy_o is 1 in IDLE, GOT_TYPE, GOT_HI and CHK; 0 in EMIT and GAP.
- IDLE:
  - Accepted byte with [7:3]==5'b10100: latch type, go to GOT_TYPE.
  - Any other accepted byte: drop it, pulse frame_err_o, stay in IDLE (resync).
- GOT_TYPE: accepted byte latched to data[15:8], go to GOT_HI.
- GOT_HI: accepted byte latched to data[7:0], then:
  - go to CHK if the macro is defined;
  - otherwise go to EMIT if type <= 5;
  - otherwise (type 6 or 7) pulse frame_err_o and return to IDLE, with no cmd_val_o.
- EMIT:
  - cmd_val_o = 1 for exactly one cycle; cmd_type_o/cmd_data_o are updated in the same cycle.
  - Latency: cmd_val_o is high in the cycle after the clock edge that accepted the last frame byte.
  - Then GAP if INTER_CMD_GAP > 0, else IDLE.
- GAP: counts INTER_CMD_GAP cycles, then IDLE.
- cmd_type_o/cmd_data_o hold their last emitted values between strobes; they never change while cmd_val_o is 0.
- Timeout:
  - Counter runs in GOT_TYPE/GOT_HI/CHK and clears on every accepted byte and on entry to IDLE.
  - When it reaches TIMEOUT_TICKS-1 with no byte accepted in that cycle: pulse frame_err_o, discard the partial frame, go to IDLE.
  - A byte accepted in the same cycle as expiry wins: the byte is taken, no error.
- err_cnt_o increments on every frame_err_o pulse and saturates at all-ones (no wrap).
- Back-to-back frames: byte_val_i may stay high continuously. Bytes are stalled only during EMIT/GAP, so the minimum frame period is 3 + 1 + INTER_CMD_GAP cycles.
- Reset mid-frame: the partial frame is lost, no cmd_val_o is issued, and err_cnt_o clears.

Optional Feature:
- Macro: TRAFFIC_CMD_CHECKSUM_EN.
- Defined:
  - Frames carry a 4th byte, byte3 = byte0 ^ byte1 ^ byte2, accepted in state CHK.
  - Mismatch: frame_err_o pulse, return to IDLE, no cmd_val_o.
  - Match: the type check proceeds as in GOT_HI (type <= 5 goes to EMIT, else error and IDLE).
  - Timeout also applies in CHK.
- Not defined: CHK state and its logic are absent; frames are 3 bytes.

Test Plan:
- Reset, then send A3 00 0A with byte_val_i continuous -> cmd_val_o pulses once, cmd_type_o=3, cmd_data_o=0x000A, one cycle after the 3rd byte; byte_rdy_o low for 1+INTER_CMD_GAP=3 cycles.
- Send A2 00 00, A3 00 0A, A4 00 0A, A5 00 0A, A0 00 00 back-to-back -> five strobes with types 2,3,4,5,0 in order, each with matching data; no frame_err_o.
- Send 55, then A4 00 0F -> one frame_err_o pulse, err_cnt_o=1, then cmd_type_o=4, cmd_data_o=0x000F.
- Send A6 12 34 -> frame_err_o pulse, no cmd_val_o, cmd_* outputs unchanged from the previous command.
- Send A3 00, then idle 2000 cycles, then A5 00 0A -> frame_err_o pulse at the timeout, then cmd_type_o=5, cmd_data_o=0x000A; the byte arriving in the expiry cycle is accepted without error.
- With TRAFFIC_CMD_CHECKSUM_EN defined: A3 00 0A A9 -> cmd strobe; A3 00 0A 00 -> frame_err_o. Assert arst_n_i mid-frame -> no strobe, err_cnt_o=0.
